// File: rtl/duty_clk_pkg.sv
// Shared types and constants for the duty-cycle clock controller.
// Holds the FSM state encoding, reset-default waveform and config legality check.
package duty_clk_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_e;

  localparam int unsigned CNT_W_C      = 8;
  localparam int unsigned DEF_PERIOD_C = 10;
  localparam int unsigned DEF_HIGH_C   = 3;

  // A period shorter than 2 cannot produce a meaningful waveform.
  function automatic logic cfg_legal(input int unsigned period, input int unsigned high);
    return (period >= 2) && (high <= period);
  endfunction

endpackage

// File: rtl/duty_counter.sv
// Period counter and registered waveform generation for duty_clk_ctrl.
// The first running cycle only arms the counter, so output starts two cycles after the start.
module duty_counter
  import duty_clk_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_C
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  output logic             wrap,
  output logic             clk_out,
  output logic             period_tick
);

  logic             armed_q;
  logic [CNT_W-1:0] count_q;
  logic             clk_q;
  logic             tick_q;

  assign wrap        = armed_q && (count_q == period - CNT_W'(1));
  assign clk_out     = clk_q;
  assign period_tick = tick_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else if (!run) begin
      armed_q <= 1'b0;
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else if (!armed_q) begin
      armed_q <= 1'b1;
      count_q <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      clk_q   <= (count_q < high);
      tick_q  <= (count_q == '0);
      count_q <= wrap ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/duty_clk_ctrl.sv
// Programmable duty-cycle clock generator: run/stop FSM plus shadow/active config.
// New settings take effect only at a period boundary, or at once when idle.
module duty_clk_ctrl
  import duty_clk_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_C,
  parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
  parameter int unsigned DEF_HIGH   = DEF_HIGH_C
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_tick,
  output logic             busy
);

  state_e           state_q;
  logic             busy_q;
  logic [CNT_W-1:0] act_period_q;
  logic [CNT_W-1:0] act_high_q;
  logic [CNT_W-1:0] shd_period_q;
  logic [CNT_W-1:0] shd_high_q;
  logic             pending_q;
  logic             ready_q;
  logic             err_q;

  logic wrap;
  logic xfer;
  logic legal;
  logic apply;

  assign xfer      = cfg_valid && ready_q;
  assign legal     = cfg_legal(32'(cfg_period), 32'(cfg_high));
  assign apply     = pending_q && (wrap || (state_q == StIdle));
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign busy      = busy_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q <= StRun;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (!enable) state_q <= StStopping;
        end
        StStopping: begin
          // A re-raised enable wins over the final wrap, so running never gaps.
          if (enable) begin
            state_q <= StRun;
          end else if (wrap) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      act_period_q <= CNT_W'(DEF_PERIOD);
      act_high_q   <= CNT_W'(DEF_HIGH);
      shd_period_q <= '0;
      shd_high_q   <= '0;
      pending_q    <= 1'b0;
      ready_q      <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      err_q <= xfer && !legal;
      if (xfer && legal) begin
        shd_period_q <= cfg_period;
        shd_high_q   <= cfg_high;
        pending_q    <= 1'b1;
        ready_q      <= 1'b0;
      end else if (apply) begin
        act_period_q <= shd_period_q;
        act_high_q   <= shd_high_q;
        pending_q    <= 1'b0;
        ready_q      <= 1'b1;
      end
    end
  end

  duty_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk_in     (clk_in),
    .rst        (rst),
    .run        (state_q != StIdle),
    .period     (act_period_q),
    .high       (act_high_q),
    .wrap       (wrap),
    .clk_out    (clk_out),
    .period_tick(period_tick)
  );

endmodule
